// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and RAM-side signals around the memory arbiter.
// slave = arbiter view, master = pipeline/RAM environment view.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data requesters: data-first with a
// streak limiter against fetch starvation and bounded retry on RAM ERROR.
module mem_arbiter #(
  parameter int          MAX_DSTREAK = 4,
  parameter int          MAX_RETRY   = 3,
  parameter logic [31:0] ERR_DATA    = 32'hBAD1BAD1
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave mem
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

  state_t        state;
  logic [SW-1:0] dstreak;
  logic [RW-1:0] retry;

  logic d_req, own_req, grant, acc_done, err_done, done, d_done, i_done;
  logic [31:0] cpl_data;

  always_comb begin
    d_req    = mem.dREN | mem.dWEN;
    own_req  = (state == DGNT) ? d_req : (state == IGNT) ? mem.iREN : 1'b0;
    grant    = (state != IDLE);
    // Reset suppresses completion so an aborted grant never hands back data.
    acc_done = grant && own_req && !RST && (mem.ramstate == RS_ACCESS);
    err_done = grant && own_req && !RST && (mem.ramstate == RS_ERROR) &&
               (retry == RW'(MAX_RETRY));
    done     = acc_done | err_done;
    d_done   = done && (state == DGNT);
    i_done   = done && (state == IGNT);
    cpl_data = err_done ? ERR_DATA : mem.ramload;
    mem.iwait   = mem.iREN && !i_done;
    mem.dwait   = d_req && !d_done;
    mem.iload   = i_done ? cpl_data : 32'h0;
    mem.dload   = d_done ? cpl_data : 32'h0;
    mem.mem_err = err_done;
  end

  // RAM-side registers double as the latched request (addr/data/we).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      dstreak      <= '0;
      retry        <= '0;
      mem.ramREN   <= 1'b0;
      mem.ramWEN   <= 1'b0;
      mem.ramaddr  <= 32'h0;
      mem.ramstore <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && (!mem.iREN || dstreak < SW'(MAX_DSTREAK))) begin
            state        <= DGNT;
            mem.ramREN   <= !mem.dWEN;
            mem.ramWEN   <= mem.dWEN;
            mem.ramaddr  <= mem.daddr;
            mem.ramstore <= mem.dstore;
          end else if (mem.iREN) begin
            state        <= IGNT;
            mem.ramREN   <= 1'b1;
            mem.ramWEN   <= 1'b0;
            mem.ramaddr  <= mem.iaddr;
            mem.ramstore <= 32'h0;
          end
        end
        default: begin
          if (!own_req || done) begin
            state        <= IDLE;
            retry        <= '0;
            mem.ramREN   <= 1'b0;
            mem.ramWEN   <= 1'b0;
            mem.ramaddr  <= 32'h0;
            mem.ramstore <= 32'h0;
          end else if (mem.ramstate == RS_ERROR) begin
            retry <= retry + 1'b1;
          end
        end
      endcase

      if (!mem.iREN || i_done)
        dstreak <= '0;
      else if (d_done && dstreak != SW'(MAX_DSTREAK))
        dstreak <= dstreak + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, starvation guard,
// error retry, request drop and reset abort.
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus();

  mem_arbiter dut (.CLK(CLK), .RST(RST), .mem(bus.slave));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'b00;
    tick(); tick();
    // reset state; waits follow requests during reset
    bus.iREN = 1; bus.dREN = 1; #1;
    chk("rst_iwait", bus.iwait, 1);
    chk("rst_dwait", bus.dwait, 1);
    chk("rst_ramREN", bus.ramREN, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_mem_err", bus.mem_err, 0);
    chk("rst_iload", bus.iload, 0);
    bus.iREN = 0; bus.dREN = 0;
    tick();
    RST = 1'b0;
    tick();

    // lone fetch
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'b00; #1;
    chk("f_c1_ramREN", bus.ramREN, 0);
    chk("f_c1_iwait", bus.iwait, 1);
    tick(); bus.ramstate = 2'b01; #1;
    chk("f_c2_ramREN", bus.ramREN, 1);
    chk("f_c2_ramaddr", bus.ramaddr, 32'h40);
    chk("f_c2_iwait", bus.iwait, 1);
    chk("f_c2_iload", bus.iload, 0);
    tick(); #1;
    chk("f_c3_iwait", bus.iwait, 1);
    tick(); bus.ramstate = 2'b10; bus.ramload = 32'h8C220004; #1;
    chk("f_acc_iwait", bus.iwait, 0);
    chk("f_acc_iload", bus.iload, 32'h8C220004);
    tick(); bus.iREN = 0; bus.ramstate = 2'b00; #1;
    chk("f_post_ramREN", bus.ramREN, 0);
    chk("f_post_iload", bus.iload, 0);

    // contention: write wins, fetch after one idle cycle
    tick();
    bus.iREN = 1; bus.iaddr = 32'h44; bus.dWEN = 1;
    bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; #1;
    chk("c_idle_dwait", bus.dwait, 1);
    tick(); bus.ramstate = 2'b01; #1;
    chk("c_d_ramWEN", bus.ramWEN, 1);
    chk("c_d_ramREN", bus.ramREN, 0);
    chk("c_d_ramstore", bus.ramstore, 32'hDEADBEEF);
    chk("c_d_ramaddr", bus.ramaddr, 32'h100);
    tick(); bus.ramstate = 2'b10; bus.ramload = 32'h0; #1;
    chk("c_d_dwait", bus.dwait, 0);
    chk("c_d_iwait", bus.iwait, 1);
    tick(); bus.dWEN = 0; bus.ramstate = 2'b00; #1;
    chk("c_gap_ramWEN", bus.ramWEN, 0);
    chk("c_gap_ramREN", bus.ramREN, 0);
    tick(); bus.ramstate = 2'b10; bus.ramload = 32'h11112222; #1;
    chk("c_i_ramREN", bus.ramREN, 1);
    chk("c_i_ramaddr", bus.ramaddr, 32'h44);
    chk("c_i_ramstore", bus.ramstore, 0);
    chk("c_i_iload", bus.iload, 32'h11112222);
    tick(); bus.iREN = 0; bus.ramstate = 2'b00;
    tick();

    // starvation guard
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h200; #1;
    for (int k = 1; k <= 4; k++) begin
      tick(); bus.ramstate = 2'b10; bus.ramload = 32'(k); #1;
      chk("s_d_ramaddr", bus.ramaddr, 32'h200);
      chk("s_d_dload", bus.dload, 32'(k));
      tick(); bus.ramstate = 2'b00; #1;
    end
    chk("s_streak_max", 32'(dut.dstreak), 4);
    tick(); bus.ramstate = 2'b10; bus.ramload = 32'hCAFE; #1;
    chk("s_i_ramaddr", bus.ramaddr, 32'h80);
    chk("s_i_iload", bus.iload, 32'hCAFE);
    chk("s_i_dwait", bus.dwait, 1);
    tick(); bus.ramstate = 2'b00; #1;
    chk("s_streak_clr", 32'(dut.dstreak), 0);
    tick(); #1;
    chk("s_d5_ramaddr", bus.ramaddr, 32'h200);
    chk("s_d5_ramREN", bus.ramREN, 1);
    bus.ramstate = 2'b10;
    tick(); bus.iREN = 0; bus.dREN = 0; bus.ramstate = 2'b00;
    tick();

    // error retry
    bus.dREN = 1; bus.daddr = 32'h300;
    tick(); bus.ramstate = 2'b11; #1;
    chk("e_r0_dwait", bus.dwait, 1);
    chk("e_r0_mem_err", bus.mem_err, 0);
    tick(); #1;
    chk("e_r1_ramREN", bus.ramREN, 1);
    chk("e_r1_dwait", bus.dwait, 1);
    tick(); #1;
    chk("e_r2_dload", bus.dload, 0);
    tick(); #1;
    chk("e_fin_dload", bus.dload, 32'hBAD1BAD1);
    chk("e_fin_dwait", bus.dwait, 0);
    chk("e_fin_mem_err", bus.mem_err, 1);
    tick(); bus.ramstate = 2'b00; bus.dREN = 0; #1;
    chk("e_post_mem_err", bus.mem_err, 0);
    chk("e_post_ramREN", bus.ramREN, 0);
    tick();

    // request dropped mid-grant
    bus.dREN = 1; bus.daddr = 32'h400;
    tick(); bus.ramstate = 2'b01; #1;
    chk("a_busy_ramREN", bus.ramREN, 1);
    tick(); bus.dREN = 0; #1;
    chk("a_drop_dload", bus.dload, 0);
    tick(); bus.ramstate = 2'b10; bus.ramload = 32'h55; #1;
    chk("a_idle_ramREN", bus.ramREN, 0);
    chk("a_idle_ramaddr", bus.ramaddr, 0);
    chk("a_idle_dload", bus.dload, 0);
    bus.ramstate = 2'b00;
    tick();

    // reset during fetch grant
    bus.iREN = 1; bus.iaddr = 32'h500;
    tick(); #1;
    chk("r_ig_ramREN", bus.ramREN, 1);
    RST = 1'b1; bus.ramstate = 2'b10; bus.ramload = 32'h77; #1;
    chk("r_iwait", bus.iwait, 1);
    chk("r_iload", bus.iload, 0);
    tick(); #1;
    chk("r_post_ramREN", bus.ramREN, 0);
    chk("r_post_ramaddr", bus.ramaddr, 0);
    chk("r_post_state", 32'(dut.state), 0);
    RST = 1'b0; bus.iREN = 0; bus.ramstate = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
